mem_arbiter: RTL
================

# mem_arbiter

Two-requester arbiter that shares the single read/write port of the unified firmware memory between the instruction-fetch unit (port 0, read-only) and the load/store unit (port 1, read/write). It accepts at most one request per cycle through valid/ready handshakes and drives the memory port combinationally. The memory reads combinationally and writes on the clock edge. The arbiter captures the read word into a per-port one-entry response slot with its own valid/ready handshake, so either requester can back-pressure without blocking the other.

## Interface
Parameters:
- DATA_PRIORITY, default 0: 0 = round-robin; 1 = port 1 wins every conflict.
- RESET_LAST_GRANT, default 1: value of the last-grant pointer after reset, so port 0 wins the first conflict.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- i_req_valid  in  1  port 0 request valid.
- i_req_ready  out  1  port 0 request accepted this cycle.
- i_req_addr  in  32  port 0 byte address.
- i_resp_valid  out  1  port 0 response slot full.
- i_resp_ready  in  1  port 0 consumer takes the response.
- i_resp_rdata  out  32  port 0 response data.
- d_req_valid / d_req_ready / d_req_addr: port 1 request handshake and address, same widths and meaning as port 0.
- d_req_wdata  in  32  port 1 write data.
- d_req_wenable  in  4  port 1 byte enables; 0 = read.
- d_resp_valid / d_resp_ready / d_resp_rdata: port 1 response handshake and data, as for port 0.
- mem_addr  out  32  memory address.
- mem_wdata  out  32  memory write data.
- mem_wenable  out  4  memory byte enables.
- mem_rdata  in  32  combinational memory read data.

## Operation
- **Eligibility.** Port p is eligible when req_valid_p = 1 and its slot can take data: resp_valid_p = 0, or resp_ready_p = 1 in the same cycle.
- **Grant.**
  - One eligible port: it is granted.
  - Both eligible, DATA_PRIORITY = 0: grant the port that is not last_grant.
  - Both eligible, DATA_PRIORITY = 1: grant port 1.
  - last_grant updates only on an actual grant.
- **Handshake.**
  - req_ready_p = grant_p. A request transfers when valid and ready are both high.
  - Requesters must not make valid depend on ready.
  - A requester holds address and data stable while valid is high and ready is low.
- **Memory drive.**
  - Port 0 granted: mem_addr = i_req_addr, mem_wenable = 0.
  - Port 1 granted: mem_addr = d_req_addr, mem_wdata = d_req_wdata, mem_wenable = d_req_wenable.
  - No grant: mem_addr = i_req_addr, mem_wdata = 0, mem_wenable = 0.
  - rst = 1 forces mem_wenable = 0 and both grants to 0.
- **Response capture.**
  - On a granted edge, the granted slot loads mem_rdata and sets resp_valid.
  - A write also produces a response; rdata is the pre-write word at that address, passed through exactly as the memory presents it (offset shift included).
- **Slot clear.** resp_valid_p = 1 and resp_ready_p = 1 with no new grant to p clears resp_valid_p; resp_rdata_p holds its value.
- **Simultaneous drain and grant.** The slot reloads; resp_valid stays 1.
- **Starvation.** Round-robin bounds the wait to 1 grant when the other port's slot is not stalled. DATA_PRIORITY = 1 may starve port 0; this is intended.

## Timing
- Reset values: resp_valid = 0, resp_rdata = 0, last_grant = RESET_LAST_GRANT, req_ready = 0.
- Request accepted in cycle N → response valid from cycle N+1, at the earliest.
- Write accepted at edge N → a read accepted in cycle N+1 returns the new data.
- Throughput: 1 request per cycle total, shared by both ports.
- No combinational path from mem_rdata to any output except through the slots.
- rst asserted mid-operation:
  - in-flight responses are discarded;
  - a write presented in the rst cycle is not performed;
  - a requester whose request was in flight must reissue it.

## Structure
- Package mem_arbiter_pkg holds:
  - localparams PORT_I = 0 and PORT_D = 1;
  - the 4-bit byte-enable width;
  - the arbitration mode encodings.
- Sub-module resp_slot: one-entry data register with valid/ready, load and clear. It is instantiated twice.
- The arbiter top contains the grant logic, the last_grant flop and the memory muxing.

## Test plan
- Reset, then memory word at 0x100 = 0xDEADBEEF; i_req_valid with addr 0x100 for 1 cycle → i_req_ready = 1, and i_resp_valid = 1 with rdata 0xDEADBEEF next cycle.
- Write at 0x200 (old word 0x11111111), wdata 0xAABBCCDD, wenable 4'b1111 → d_resp_rdata = 0x11111111. A read of 0x200 on the next cycle returns 0xAABBCCDD.
- Both ports request every cycle, DATA_PRIORITY = 0 → grants alternate 0,1,0,1 starting with port 0.
- Both ports request every cycle, DATA_PRIORITY = 1 → port 1 granted every cycle, port 0 never granted.
- Hold i_resp_ready = 0 after one port 0 response:
  - i_req_ready stays 0 and port 1 keeps being granted;
  - raise i_resp_ready → the slot drains and reloads in the same cycle.
- Assert rst while d_req_valid with wenable 4'b0011 is presented → mem_wenable = 0, the memory is unchanged, and all resp_valid = 0 the next cycle.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the firmware-memory arbiter: port indices,
// byte-enable width and arbitration mode encodings.
// No logic; imported by the arbiter top.
package mem_arbiter_pkg;
    localparam int PORT_I          = 0;
    localparam int PORT_D          = 1;
    localparam int BE_W            = 4;
    localparam int ARB_ROUND_ROBIN = 0;
    localparam int ARB_DATA_FIRST  = 1;
endpackage

// File: rtl/mem_arbiter_resp_slot.sv
// One-entry response register with valid/ready handshake.
// Load takes effect on the next edge; a load wins over a same-cycle drain.
// Backpressure: holds data while valid and ready is low; data held after clear.
module resp_slot #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_data,
    output logic         valid,
    input  logic         ready,
    output logic [W-1:0] data
);

    // Load has priority so a drain and a new grant in one cycle keeps the slot full.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one combinational-read memory port between fetch (port 0) and load/store (port 1).
// Grant and memory drive are combinational; responses appear one cycle after acceptance.
// A port whose response slot is full and not draining is not granted; the other port proceeds.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int   DATA_PRIORITY    = ARB_ROUND_ROBIN,
    parameter logic RESET_LAST_GRANT = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_req_valid,
    output logic            i_req_ready,
    input  logic [31:0]     i_req_addr,
    output logic            i_resp_valid,
    input  logic            i_resp_ready,
    output logic [31:0]     i_resp_rdata,
    input  logic            d_req_valid,
    output logic            d_req_ready,
    input  logic [31:0]     d_req_addr,
    input  logic [31:0]     d_req_wdata,
    input  logic [BE_W-1:0] d_req_wenable,
    output logic            d_resp_valid,
    input  logic            d_resp_ready,
    output logic [31:0]     d_resp_rdata,
    output logic [31:0]     mem_addr,
    output logic [31:0]     mem_wdata,
    output logic [BE_W-1:0] mem_wenable,
    input  logic [31:0]     mem_rdata
);

    logic elig_i;
    logic elig_d;
    logic grant_i;
    logic grant_d;
    logic last_grant;

    // Eligibility and grant selection; reset suppresses all grants.
    always_comb begin
        elig_i  = i_req_valid && (!i_resp_valid || i_resp_ready);
        elig_d  = d_req_valid && (!d_resp_valid || d_resp_ready);
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (!rst) begin
            if (elig_i && elig_d) begin
                if (DATA_PRIORITY == ARB_DATA_FIRST) begin
                    grant_d = 1'b1;
                end else if (last_grant == 1'(PORT_D)) begin
                    grant_i = 1'b1;
                end else begin
                    grant_d = 1'b1;
                end
            end else begin
                grant_i = elig_i;
                grant_d = elig_d;
            end
        end
    end

    assign i_req_ready = grant_i;
    assign d_req_ready = grant_d;

    // Remember the most recent winner; idle cycles leave it untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= RESET_LAST_GRANT;
        end else if (grant_i) begin
            last_grant <= 1'(PORT_I);
        end else if (grant_d) begin
            last_grant <= 1'(PORT_D);
        end
    end

    // Memory port mux: fetch address by default, load/store fields only when port 1 wins.
    always_comb begin
        mem_addr    = i_req_addr;
        mem_wdata   = '0;
        mem_wenable = '0;
        if (grant_d) begin
            mem_addr    = d_req_addr;
            mem_wdata   = d_req_wdata;
            mem_wenable = d_req_wenable;
        end
    end

    resp_slot #(.W(32)) u_slot_i (
        .clk       (clk),
        .rst       (rst),
        .load      (grant_i),
        .load_data (mem_rdata),
        .valid     (i_resp_valid),
        .ready     (i_resp_ready),
        .data      (i_resp_rdata)
    );

    resp_slot #(.W(32)) u_slot_d (
        .clk       (clk),
        .rst       (rst),
        .load      (grant_d),
        .load_data (mem_rdata),
        .valid     (d_resp_valid),
        .ready     (d_resp_ready),
        .data      (d_resp_rdata)
    );

endmodule
